// File: rtl/tlb_pkg.sv
// Shared TLB entry layout and the match rule used by lookup channels and the probe.
package tlb_pkg;

  localparam int unsigned ENTRY_W    = 80;
  localparam int unsigned ASID_HI    = 79;
  localparam int unsigned ASID_LO    = 72;
  localparam int unsigned G_BIT      = 71;
  localparam int unsigned VPN2_HI    = 70;
  localparam int unsigned VPN2_LO    = 52;
  localparam int unsigned PFN1_HI    = 51;
  localparam int unsigned PFN1_LO    = 28;
  localparam int unsigned D1_BIT     = 27;
  localparam int unsigned V1_BIT     = 26;
  localparam int unsigned PFN0_HI    = 25;
  localparam int unsigned PFN0_LO    = 2;
  localparam int unsigned D0_BIT     = 1;
  localparam int unsigned V0_BIT     = 0;

  localparam int unsigned VPN2_W     = VPN2_HI - VPN2_LO + 1;
  localparam int unsigned ENT_ASID_W = ASID_HI - ASID_LO + 1;
  localparam int unsigned ENT_PFN_W  = PFN0_HI - PFN0_LO + 1;

  typedef logic [ENTRY_W-1:0] tlb_entry_t;

  function automatic logic tlb_match(input tlb_entry_t e,
                                     input logic [VPN2_W-1:0] vpn2,
                                     input logic [ENT_ASID_W-1:0] asid);
    return (e[VPN2_HI:VPN2_LO] == vpn2) &&
           (e[G_BIT] || (e[ASID_HI:ASID_LO] == asid));
  endfunction

endpackage

// File: rtl/tlb_lookup_port.sv
// One registered TLB lookup channel: lowest-index priority match, even/odd page select.
module tlb_lookup_port
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_req,
  input  logic [31:0]                i_vaddr,
  input  logic [ENT_ASID_W-1:0]      i_asid,
  input  logic [ENTRIES*ENTRY_W-1:0] i_entries,
  output logic                       o_rsp,
  output logic [31:0]                o_paddr,
  output logic                       o_miss,
  output logic                       o_valid,
  output logic                       o_dirty
);

  logic        w_hit;
  logic [19:0] w_pfn;
  logic        w_v;
  logic        w_d;

  always_comb begin
    w_hit = 1'b0;
    w_pfn = '0;
    w_v   = 1'b0;
    w_d   = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!w_hit && tlb_match(i_entries[i*ENTRY_W +: ENTRY_W], i_vaddr[31:13], i_asid)) begin
        w_hit = 1'b1;
        if (i_vaddr[12]) begin
          w_pfn = i_entries[i*ENTRY_W + PFN1_LO +: 20];
          w_v   = i_entries[i*ENTRY_W + V1_BIT];
          w_d   = i_entries[i*ENTRY_W + D1_BIT];
        end else begin
          w_pfn = i_entries[i*ENTRY_W + PFN0_LO +: 20];
          w_v   = i_entries[i*ENTRY_W + V0_BIT];
          w_d   = i_entries[i*ENTRY_W + D0_BIT];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rsp   <= 1'b0;
      o_paddr <= '0;
      o_miss  <= 1'b0;
      o_valid <= 1'b0;
      o_dirty <= 1'b0;
    end else begin
      o_rsp <= i_req;
      if (i_req) begin
        o_paddr <= w_hit ? {w_pfn, i_vaddr[11:0]} : '0;
        o_miss  <= ~w_hit;
        o_valid <= w_v;
        o_dirty <= w_d;
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// TLB array, CP0 TLB instructions, Random/Wired counter and NCH lookup channels.
// Optional global invalidate port enabled by defining TLB_FLUSH_EN.
module tlb_unit
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned NCH     = 2,
  parameter int unsigned ASID_W  = 8,
  parameter int unsigned PFN_W   = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      lk_req,
  input  logic [32*NCH-1:0]   lk_vaddr,
  input  logic [ASID_W-1:0]   asid,
  output logic [NCH-1:0]      lk_rsp,
  output logic [32*NCH-1:0]   lk_paddr,
  output logic [NCH-1:0]      lk_miss,
  output logic [NCH-1:0]      lk_valid,
  output logic [NCH-1:0]      lk_dirty,
  input  logic                tlbwi,
  input  logic                tlbwr,
  input  logic                tlbr,
  input  logic                tlbp,
  input  logic [IDX_W-1:0]    index_in,
  input  logic [IDX_W-1:0]    wired_in,
  input  logic                wired_we,
`ifdef TLB_FLUSH_EN
  input  logic                flush,
`endif
  input  logic [ENTRY_W-1:0]  wr_entry,
  output logic [ENTRY_W-1:0]  rd_entry,
  output logic                rd_done,
  output logic [31:0]         tlbp_result,
  output logic                tlbp_done,
  output logic [IDX_W-1:0]    random_out
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(ENTRIES - 1);

  if (PFN_W != ENT_PFN_W || (1 << IDX_W) != ENTRIES) begin : g_param_check
    $error("tlb_unit: inconsistent PFN_W/IDX_W/ENTRIES");
  end

  logic [ENTRIES-1:0][ENTRY_W-1:0] r_entries;
  logic [IDX_W-1:0]                r_random;
  logic [IDX_W-1:0]                r_wired;
  logic [ENTRY_W-1:0]              r_rd_entry;
  logic                            r_rd_done;
  logic [31:0]                     r_tlbp_result;
  logic                            r_tlbp_done;

  logic [IDX_W-1:0]                w_random_nxt;
  logic [IDX_W-1:0]                w_wired_nxt;
  logic                            w_wr_en;
  logic [IDX_W-1:0]                w_wr_idx;
  logic                            w_probe_hit;
  logic [IDX_W-1:0]                w_probe_idx;
  logic [ENT_ASID_W-1:0]           w_asid;

  assign w_asid = ENT_ASID_W'(asid);

  // Random counts down towards Wired, then wraps to the top; a Wired write restarts it.
  always_comb begin
    w_random_nxt = r_random - 1'b1;
    w_wired_nxt  = r_wired;
    if (wired_we) begin
      w_wired_nxt  = wired_in;
      w_random_nxt = MAX_IDX;
    end else if (r_wired >= MAX_IDX || r_random <= r_wired) begin
      w_random_nxt = MAX_IDX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_random <= MAX_IDX;
      r_wired  <= '0;
    end else begin
      r_random <= w_random_nxt;
      r_wired  <= w_wired_nxt;
    end
  end

  assign w_wr_en  = tlbwi | tlbwr;
  assign w_wr_idx = tlbwi ? index_in : r_random;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entries <= '0;
    end else begin
`ifdef TLB_FLUSH_EN
      if (flush) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          r_entries[i][V0_BIT] <= 1'b0;
          r_entries[i][V1_BIT] <= 1'b0;
          r_entries[i][G_BIT]  <= 1'b0;
        end
      end else if (w_wr_en) begin
        r_entries[w_wr_idx] <= wr_entry;
      end
`else
      if (w_wr_en) begin
        r_entries[w_wr_idx] <= wr_entry;
      end
`endif
    end
  end

  always_comb begin
    w_probe_hit = 1'b0;
    w_probe_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!w_probe_hit && tlb_match(r_entries[i], wr_entry[VPN2_HI:VPN2_LO], w_asid)) begin
        w_probe_hit = 1'b1;
        w_probe_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_entry    <= '0;
      r_rd_done     <= 1'b0;
      r_tlbp_result <= '0;
      r_tlbp_done   <= 1'b0;
    end else begin
      r_rd_done   <= tlbr;
      r_tlbp_done <= tlbp;
      if (tlbr) begin
        r_rd_entry <= r_entries[index_in];
      end
      if (tlbp) begin
        r_tlbp_result <= {~w_probe_hit, {(31-IDX_W){1'b0}}, w_probe_idx};
      end
    end
  end

  assign rd_entry    = r_rd_entry;
  assign rd_done     = r_rd_done;
  assign tlbp_result = r_tlbp_result;
  assign tlbp_done   = r_tlbp_done;
  assign random_out  = r_random;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tlb_lookup_port #(
      .ENTRIES(ENTRIES)
    ) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (lk_req[c]),
      .i_vaddr  (lk_vaddr[32*c +: 32]),
      .i_asid   (w_asid),
      .i_entries(r_entries),
      .o_rsp    (lk_rsp[c]),
      .o_paddr  (lk_paddr[32*c +: 32]),
      .o_miss   (lk_miss[c]),
      .o_valid  (lk_valid[c]),
      .o_dirty  (lk_dirty[c])
    );
  end

endmodule

// File: tb/tb_tlb_unit.sv
// Directed self-checking bench for tlb_unit (default 16 entries, 2 channels).
module tb_tlb_unit;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned NCH     = 2;
  localparam int unsigned ASID_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    lk_req;
  logic [32*NCH-1:0] lk_vaddr;
  logic [ASID_W-1:0] asid;
  logic [NCH-1:0]    lk_rsp, lk_miss, lk_valid, lk_dirty;
  logic [32*NCH-1:0] lk_paddr;
  logic              tlbwi, tlbwr, tlbr, tlbp, wired_we;
  logic [IDX_W-1:0]  index_in, wired_in, random_out;
  logic [79:0]       wr_entry, rd_entry;
  logic              rd_done, tlbp_done;
  logic [31:0]       tlbp_result;
`ifdef TLB_FLUSH_EN
  logic              flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [79:0] e3, e7, e2, e9, e5;

  always #5 clk = ~clk;

  tlb_unit #(
    .ENTRIES(ENTRIES), .IDX_W(IDX_W), .NCH(NCH), .ASID_W(ASID_W), .PFN_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_req(lk_req), .lk_vaddr(lk_vaddr), .asid(asid),
    .lk_rsp(lk_rsp), .lk_paddr(lk_paddr), .lk_miss(lk_miss),
    .lk_valid(lk_valid), .lk_dirty(lk_dirty),
    .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbr(tlbr), .tlbp(tlbp),
    .index_in(index_in), .wired_in(wired_in), .wired_we(wired_we),
`ifdef TLB_FLUSH_EN
    .flush(flush),
`endif
    .wr_entry(wr_entry), .rd_entry(rd_entry), .rd_done(rd_done),
    .tlbp_result(tlbp_result), .tlbp_done(tlbp_done), .random_out(random_out)
  );

  function automatic logic [79:0] mk(input logic [7:0] a, input logic g, input logic [18:0] vpn2,
                                     input logic [23:0] pfn1, input logic d1, input logic v1,
                                     input logic [23:0] pfn0, input logic d0, input logic v0);
    return {a, g, vpn2, pfn1, d1, v1, pfn0, d0, v0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [79:0] e);
    index_in = idx; wr_entry = e; tlbwi = 1'b1;
    step();
    tlbwi = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] idx);
    index_in = idx; tlbr = 1'b1;
    step();
    tlbr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lk_req = '0; lk_vaddr = '0; asid = '0;
    tlbwi = 0; tlbwr = 0; tlbr = 0; tlbp = 0; wired_we = 0;
    index_in = '0; wired_in = '0; wr_entry = '0;
`ifdef TLB_FLUSH_EN
    flush = 1'b0;
`endif
    #12;
    n_tests++;
    if (random_out !== 4'd15) begin n_fail++; $display("FAIL reset_random: got %0d want 15", random_out); end
    n_tests++;
    if ({lk_rsp, lk_miss, lk_paddr, rd_done, tlbp_done, tlbp_result} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero strobes/outputs");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    lk_req = 2'b01; lk_vaddr[31:0] = 32'h0040_0000;
    step();
    lk_req = '0;
    n_tests++;
    if (lk_rsp !== 2'b01 || lk_miss[0] !== 1'b1 || lk_paddr[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL empty_lookup: got rsp=%b miss=%b pa=%h want rsp=01 miss=1 pa=0",
                         lk_rsp, lk_miss[0], lk_paddr[31:0]);
    end
  endtask

  task automatic test_tlbwi();
    e3 = mk(8'd5, 1'b0, 19'h00200, 24'h0, 1'b0, 1'b0, 24'h000123, 1'b1, 1'b1);
    // channel 1 looks up during the write cycle and must see the old (empty) entry
    asid = 8'd5; lk_req = 2'b10; lk_vaddr[63:32] = 32'h0040_0ABC;
    do_write(4'd3, e3);
    lk_req = '0;
    n_tests++;
    if (lk_rsp[1] !== 1'b1 || lk_miss[1] !== 1'b1) begin
      n_fail++; $display("FAIL write_cycle_lookup: got rsp=%b miss=%b want 1 1", lk_rsp[1], lk_miss[1]);
    end
    lk_req = 2'b01; lk_vaddr[31:0] = 32'h0040_0ABC;
    step();
    lk_req = '0;
    n_tests++;
    if (lk_miss[0] !== 1'b0 || lk_paddr[31:0] !== 32'h0012_3ABC || lk_valid[0] !== 1'b1 || lk_dirty[0] !== 1'b1) begin
      n_fail++; $display("FAIL hit_asid5: got miss=%b pa=%h v=%b d=%b want 0 00123abc 1 1",
                         lk_miss[0], lk_paddr[31:0], lk_valid[0], lk_dirty[0]);
    end
    step();
    n_tests++;
    if (lk_rsp[0] !== 1'b0 || lk_paddr[31:0] !== 32'h0012_3ABC) begin
      n_fail++; $display("FAIL idle_hold: got rsp=%b pa=%h want 0 00123abc", lk_rsp[0], lk_paddr[31:0]);
    end
    asid = 8'd6; lk_req = 2'b01;
    step();
    lk_req = '0;
    n_tests++;
    if (lk_miss[0] !== 1'b1 || lk_paddr[31:0] !== 32'h0 || lk_valid[0] !== 1'b0 || lk_dirty[0] !== 1'b0) begin
      n_fail++; $display("FAIL miss_asid6: got miss=%b pa=%h v=%b d=%b want 1 0 0 0",
                         lk_miss[0], lk_paddr[31:0], lk_valid[0], lk_dirty[0]);
    end
  endtask

  task automatic test_global();
    e3 = mk(8'd5, 1'b1, 19'h00200, 24'h000456, 1'b0, 1'b1, 24'h000123, 1'b1, 1'b1);
    do_write(4'd3, e3);
    asid = 8'd9; lk_req = 2'b11;
    lk_vaddr[31:0] = 32'h0040_0ABC; lk_vaddr[63:32] = 32'h0040_1010;
    step();
    lk_req = '0;
    n_tests++;
    if (lk_rsp !== 2'b11 || lk_paddr[63:32] !== 32'h0045_6010 || lk_valid[1] !== 1'b1 || lk_dirty[1] !== 1'b0 || lk_miss[1] !== 1'b0) begin
      n_fail++; $display("FAIL global_odd: got rsp=%b pa=%h v=%b d=%b m=%b want 11 00456010 1 0 0",
                         lk_rsp, lk_paddr[63:32], lk_valid[1], lk_dirty[1], lk_miss[1]);
    end
    n_tests++;
    if (lk_paddr[31:0] !== 32'h0012_3ABC || lk_valid[0] !== 1'b1 || lk_dirty[0] !== 1'b1) begin
      n_fail++; $display("FAIL global_even: got pa=%h v=%b d=%b want 00123abc 1 1",
                         lk_paddr[31:0], lk_valid[0], lk_dirty[0]);
    end
  endtask

  task automatic test_back_to_back();
    asid = 8'd9;
    lk_req = 2'b01; lk_vaddr[31:0] = 32'h0040_1010;
    step();
    n_tests++;
    if (lk_rsp !== 2'b01 || lk_paddr[31:0] !== 32'h0045_6010 || lk_dirty[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: got rsp=%b pa=%h d=%b want 01 00456010 0", lk_rsp, lk_paddr[31:0], lk_dirty[0]);
    end
    lk_vaddr[31:0] = 32'h0040_0FFF;
    step();
    lk_req = '0;
    n_tests++;
    if (lk_rsp !== 2'b01 || lk_paddr[31:0] !== 32'h0012_3FFF || lk_dirty[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got rsp=%b pa=%h d=%b want 01 00123fff 1", lk_rsp, lk_paddr[31:0], lk_dirty[0]);
    end
  endtask

  task automatic test_random();
    wired_in = 4'd4; wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    n_tests++;
    if (random_out !== 4'd15) begin n_fail++; $display("FAIL wired_restart: got %0d want 15", random_out); end
    for (int k = 14; k >= 4; k--) begin
      step();
      n_tests++;
      if (random_out !== 4'(k)) begin n_fail++; $display("FAIL random_seq: got %0d want %0d", random_out, k); end
    end
    step();
    n_tests++;
    if (random_out !== 4'd15) begin n_fail++; $display("FAIL random_wrap: got %0d want 15", random_out); end
    for (int i = 0; i < 20 && random_out !== 4'd7; i++) step();
    n_tests++;
    if (random_out !== 4'd7) begin n_fail++; $display("FAIL random_reach7: got %0d want 7", random_out); end
    e7 = mk(8'h22, 1'b0, 19'h12345, 24'h00ABCD, 1'b1, 1'b0, 24'h00BEEF, 1'b0, 1'b1);
    wr_entry = e7; index_in = 4'd0; tlbwr = 1'b1;
    step();
    tlbwr = 1'b0;
    do_read(4'd7);
    n_tests++;
    if (rd_done !== 1'b1 || rd_entry !== e7) begin
      n_fail++; $display("FAIL tlbwr_read: got done=%b entry=%h want 1 %h", rd_done, rd_entry, e7);
    end
    step();
    n_tests++;
    if (rd_done !== 1'b0 || rd_entry !== e7) begin
      n_fail++; $display("FAIL tlbr_hold: got done=%b entry=%h want 0 %h", rd_done, rd_entry, e7);
    end
    do_read(4'd0);
    n_tests++;
    if (rd_entry !== 80'h0) begin n_fail++; $display("FAIL tlbwr_index0_untouched: got %h want 0", rd_entry); end
  endtask

  task automatic test_probe();
    e2 = mk(8'h11, 1'b0, 19'h3AAAA, 24'h0, 1'b0, 1'b0, 24'h000002, 1'b0, 1'b1);
    e9 = mk(8'h11, 1'b0, 19'h3AAAA, 24'h0, 1'b0, 1'b0, 24'h000009, 1'b0, 1'b1);
    do_write(4'd9, e9);
    do_write(4'd2, e2);
    asid = 8'h11;
    wr_entry = mk(8'h00, 1'b0, 19'h3AAAA, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    tlbp = 1'b1;
    lk_req = 2'b01; lk_vaddr[31:0] = {19'h3AAAA, 13'h0345};
    step();
    tlbp = 1'b0; lk_req = '0;
    n_tests++;
    if (tlbp_done !== 1'b1 || tlbp_result !== 32'h0000_0002) begin
      n_fail++; $display("FAIL probe_dup: got done=%b res=%h want 1 00000002", tlbp_done, tlbp_result);
    end
    n_tests++;
    if (lk_paddr[31:0] !== 32'h0000_2345) begin
      n_fail++; $display("FAIL lookup_dup: got pa=%h want 00002345", lk_paddr[31:0]);
    end
    step();
    n_tests++;
    if (tlbp_done !== 1'b0 || tlbp_result !== 32'h0000_0002) begin
      n_fail++; $display("FAIL probe_hold: got done=%b res=%h want 0 00000002", tlbp_done, tlbp_result);
    end
    wr_entry = mk(8'h00, 1'b0, 19'h7FFFF, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    tlbp = 1'b1;
    step();
    tlbp = 1'b0;
    n_tests++;
    if (tlbp_done !== 1'b1 || tlbp_result !== 32'h8000_0000) begin
      n_fail++; $display("FAIL probe_absent: got done=%b res=%h want 1 80000000", tlbp_done, tlbp_result);
    end
  endtask

  task automatic test_wi_wr_same();
    for (int i = 0; i < 20 && random_out !== 4'd12; i++) step();
    n_tests++;
    if (random_out !== 4'd12) begin n_fail++; $display("FAIL random_reach12: got %0d want 12", random_out); end
    e5 = mk(8'h33, 1'b0, 19'h05555, 24'h0, 1'b0, 1'b0, 24'h000555, 1'b1, 1'b1);
    index_in = 4'd5; wr_entry = e5; tlbwi = 1'b1; tlbwr = 1'b1;
    step();
    tlbwi = 1'b0; tlbwr = 1'b0;
    do_read(4'd5);
    n_tests++;
    if (rd_entry !== e5) begin n_fail++; $display("FAIL both_wi_entry: got %h want %h", rd_entry, e5); end
    do_read(4'd12);
    n_tests++;
    if (rd_entry !== 80'h0) begin n_fail++; $display("FAIL both_wr_dropped: got %h want 0", rd_entry); end
  endtask

`ifdef TLB_FLUSH_EN
  task automatic test_flush();
    flush = 1'b1;
    index_in = 4'd10; wr_entry = e5; tlbwi = 1'b1;
    asid = 8'd9; lk_req = 2'b10; lk_vaddr[63:32] = 32'h0040_1010;
    step();
    flush = 1'b0; tlbwi = 1'b0; lk_req = '0;
    n_tests++;
    if (lk_valid[1] !== 1'b1 || lk_paddr[63:32] !== 32'h0045_6010) begin
      n_fail++; $display("FAIL flush_cycle_lookup: got v=%b pa=%h want 1 00456010", lk_valid[1], lk_paddr[63:32]);
    end
    lk_req = 2'b01; lk_vaddr[31:0] = 32'h0040_0ABC;
    step();
    n_tests++;
    if (lk_miss[0] !== 1'b1) begin n_fail++; $display("FAIL flush_g_cleared: got miss=%b want 1", lk_miss[0]); end
    asid = 8'd5;
    step();
    lk_req = '0;
    n_tests++;
    if (lk_miss[0] !== 1'b0 || lk_valid[0] !== 1'b0 || lk_paddr[31:0] !== 32'h0012_3ABC) begin
      n_fail++; $display("FAIL flush_v_cleared: got m=%b v=%b pa=%h want 0 0 00123abc",
                         lk_miss[0], lk_valid[0], lk_paddr[31:0]);
    end
    do_read(4'd10);
    n_tests++;
    if (rd_entry !== 80'h0) begin n_fail++; $display("FAIL flush_write_dropped: got %h want 0", rd_entry); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tlbwi();
    test_global();
    test_back_to_back();
    test_random();
    test_probe();
    test_wi_wr_same();
`ifdef TLB_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
